// File: rtl/pulse_filter_pkg.sv
// pulse_filter_pkg: FSM state encoding and default parameters for the pulse filter.
package pulse_filter_pkg;
    typedef enum logic [1:0] {IDLE_LOW, QUAL_HIGH, STABLE_HIGH, QUAL_LOW} state_t;
    localparam int DEF_SYNC_STAGES = 2;
    localparam int DEF_MIN_WIDTH   = 4;
    localparam int DEF_CNT_W       = 8;
    localparam int QCNT_W          = 4;
endpackage

// File: rtl/pulse_filter_if.sv
// pulse_filter_if: raw level in, filtered level/edges/width/glitch out.
interface pulse_filter_if import pulse_filter_pkg::*; #(parameter int CNT_W = DEF_CNT_W);
    logic             a;
    logic             out;
    logic             rise;
    logic             fall;
    logic [CNT_W-1:0] width;
    logic             width_valid;
    logic             glitch;
    modport master (output a, input out, rise, fall, width, width_valid, glitch);
    modport slave  (input a, output out, rise, fall, width, width_valid, glitch);
endinterface

// File: rtl/sync_ff.sv
// sync_ff: multi-stage synchronizer for an asynchronous level.
module sync_ff import pulse_filter_pkg::*; #(
    parameter int STAGES = DEF_SYNC_STAGES
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);
    logic [STAGES-1:0] r_sync;
    always_ff @(posedge clk) r_sync <= rst ? '0 : {r_sync[STAGES-2:0], d};
    assign q = r_sync[STAGES-1];
endmodule

// File: rtl/pulse_filter.sv
// pulse_filter: deglitches an async level and measures accepted high-pulse widths.
module pulse_filter import pulse_filter_pkg::*; #(
    parameter int SYNC_STAGES = DEF_SYNC_STAGES,
    parameter int MIN_WIDTH   = DEF_MIN_WIDTH,
    parameter int CNT_W       = DEF_CNT_W
) (
    input  logic clk,
    input  logic rst,
    pulse_filter_if.slave bus
);
    localparam logic [QCNT_W-1:0] QMAX = QCNT_W'(MIN_WIDTH - 1);
    logic              w_a_s;
    state_t            r_state;
    logic [QCNT_W-1:0] r_qcnt;
    logic [CNT_W-1:0]  r_wcnt;
    logic [CNT_W-1:0]  r_width;
    logic              r_out;
    logic              r_rise;
    logic              r_fall;
    logic              r_wv;
    logic              r_glitch;

    function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] x, input logic [QCNT_W-1:0] y);
        logic [CNT_W:0] s;
        s = {1'b0, x} + (CNT_W+1)'(y);
        return s[CNT_W] ? '1 : s[CNT_W-1:0];
    endfunction

    sync_ff #(.STAGES(SYNC_STAGES)) u_sync (.clk(clk), .rst(rst), .d(bus.a), .q(w_a_s));

    // a rejected low dip is credited back to the width once it turns out to be a glitch
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= IDLE_LOW;
            r_qcnt   <= '0;
            r_wcnt   <= '0;
            r_width  <= '0;
            r_out    <= 1'b0;
            r_rise   <= 1'b0;
            r_fall   <= 1'b0;
            r_wv     <= 1'b0;
            r_glitch <= 1'b0;
        end else begin
            r_rise   <= 1'b0;
            r_fall   <= 1'b0;
            r_wv     <= 1'b0;
            r_glitch <= 1'b0;
            case (r_state)
                IDLE_LOW: if (w_a_s) begin
                    r_state <= QUAL_HIGH;
                    r_qcnt  <= QCNT_W'(1);
                    r_wcnt  <= '0;
                end
                QUAL_HIGH: begin
                    r_wcnt <= sat_add(r_wcnt, QCNT_W'(1));
                    if (!w_a_s) begin
                        r_state  <= IDLE_LOW;
                        r_glitch <= 1'b1;
                    end else if (r_qcnt == QMAX) begin
                        r_state <= STABLE_HIGH;
                        r_out   <= 1'b1;
                        r_rise  <= 1'b1;
                    end else r_qcnt <= r_qcnt + 1'b1;
                end
                STABLE_HIGH: begin
                    r_wcnt <= sat_add(r_wcnt, QCNT_W'(1));
                    if (!w_a_s) begin
                        r_state <= QUAL_LOW;
                        r_qcnt  <= QCNT_W'(1);
                    end
                end
                QUAL_LOW: if (w_a_s) begin
                    r_state  <= STABLE_HIGH;
                    r_glitch <= 1'b1;
                    r_wcnt   <= sat_add(r_wcnt, r_qcnt);
                end else if (r_qcnt == QMAX) begin
                    r_state <= IDLE_LOW;
                    r_out   <= 1'b0;
                    r_fall  <= 1'b1;
                    r_wv    <= 1'b1;
                    r_width <= r_wcnt;
                end else r_qcnt <= r_qcnt + 1'b1;
            endcase
        end
    end

    assign bus.out         = r_out;
    assign bus.rise        = r_rise;
    assign bus.fall        = r_fall;
    assign bus.width       = r_width;
    assign bus.width_valid = r_wv;
    assign bus.glitch      = r_glitch;
endmodule

// File: doc/pulse_filter.md
PULSE_FILTER -- requirements
Module: pulse_filter

Interface
REQ-001 Parameter SYNC_STAGES, default 2, SHALL set the number of flip-flops in the input synchronizer (legal 2..4).
REQ-002 Parameter MIN_WIDTH, default 4, SHALL set the consecutive synchronized cycles needed to accept a level change (legal 2..15).
REQ-003 Parameter CNT_W, default 8, SHALL set the width of the pulse-width counter and the width output (legal 4..16).
REQ-004 clk  input  1  SHALL be the single clock; every register updates on its rising edge.
REQ-005 rst  input  1  SHALL be the synchronous, active-high reset, sampled on the clk rising edge.
REQ-006 a  input  1  SHALL be the asynchronous level from the upstream transport_delay stage.
REQ-007 out  output  1  SHALL be the filtered, glitch-free level.
REQ-008 rise  output  1  SHALL pulse for one cycle when out goes 0->1.
REQ-009 fall  output  1  SHALL pulse for one cycle when out goes 1->0.
REQ-010 width  output  CNT_W  SHALL hold the last measured high-pulse width in clk cycles.
REQ-011 width_valid  output  1  SHALL pulse for one cycle when width updates, coincident with fall.
REQ-012 glitch  output  1  SHALL pulse for one cycle when a level excursion shorter than MIN_WIDTH is rejected.

Function
REQ-013 a SHALL pass through SYNC_STAGES flip-flops; the last stage is a_s, and only a_s feeds the FSM.
REQ-014 FSM states SHALL be IDLE_LOW, QUAL_HIGH, STABLE_HIGH, QUAL_LOW, with a qualification counter qcnt.
REQ-015 IDLE_LOW: a_s=1 -> QUAL_HIGH with qcnt=1; otherwise stay.
REQ-016 QUAL_HIGH: a_s=1 and qcnt=MIN_WIDTH-1 -> STABLE_HIGH, out=1, rise=1; a_s=1 otherwise -> qcnt+1; a_s=0 -> IDLE_LOW, glitch=1.
REQ-017 STABLE_HIGH: a_s=0 -> QUAL_LOW with qcnt=1; otherwise stay.
REQ-018 QUAL_LOW: a_s=0 and qcnt=MIN_WIDTH-1 -> IDLE_LOW, out=0, fall=1, width_valid=1; a_s=0 otherwise -> qcnt+1; a_s=1 -> STABLE_HIGH, glitch=1, out stays 1.
REQ-019 Latency: if edge k is the first to sample a=1 into stage 1, out SHALL assert at edge k+SYNC_STAGES+MIN_WIDTH-1 (k+5 at defaults); the falling direction is symmetric.
REQ-020 The width counter SHALL clear on entry to QUAL_HIGH and increment each cycle in QUAL_HIGH, STABLE_HIGH and rejected QUAL_LOW excursions; it SHALL NOT increment in accepted QUAL_LOW cycles, so width equals the a_s high duration.
REQ-021 The width counter SHALL saturate at 2^CNT_W-1 and never wrap.
REQ-022 width SHALL load on the width_valid cycle and hold until the next width_valid.
REQ-023 A rejected high glitch SHALL leave width unchanged.
REQ-024 rise, fall, width_valid and glitch SHALL be registered and last exactly one cycle; rise and fall are never asserted together.

Reset
REQ-025 While rst=1: state=IDLE_LOW, all synchronizer stages=0, qcnt=0, width counter=0, out=0, rise=0, fall=0, width=0, width_valid=0, glitch=0.
REQ-026 Reset asserted mid-pulse SHALL drop out to 0 without a fall or width_valid pulse.
REQ-027 An a held high through reset release SHALL require full re-qualification per REQ-019.

Structure
REQ-028 Package pulse_filter_pkg SHALL hold the FSM state enum and the default parameter constants.
REQ-029 The synchronizer SHALL be a sub-module sync_ff (parameter STAGES, ports clk, rst, d, q), instantiated once.

Verification (clk period 10 ns, defaults)
REQ-030 a=1 for 10 cycles, then 0 -> out rises 5 cycles after the first sampling edge; width=10 with width_valid and fall in the same cycle.
REQ-031 a=1 for 3 cycles -> glitch=1 once; out, rise and width unchanged.
REQ-032 Stable high with a 2-cycle low dip, total high period 20 cycles -> one glitch, no fall during the dip, final width=20.
REQ-033 With CNT_W=4, a=1 for 40 cycles -> width=15 (saturated).
REQ-034 rst=1 for 1 cycle while out=1 -> next cycle out=0, no fall or width_valid pulse; with a still 1, out returns 5 cycles after rst release.
REQ-035 Back-to-back accepted pulses of 6 and 9 cycles with 5-cycle gaps -> width_valid twice, with width=6 then width=9.
